// File: rtl/instr_fetch_queue_if.sv
// Instruction memory request/response port bundle.
// Responses return strictly in request order.
interface instr_fetch_queue_if;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [15:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Prefetching instruction fetch queue with in-order imem
// responses, redirect flush and stale-response dropping.
module instr_fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [15:0] RESET_PC        = 16'h0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        redirect_valid,
  input  logic [15:0]                 redirect_pc,
  input  logic                        halt,
  instr_fetch_queue_if.master         imem,
  output logic                        instr_valid,
  output logic [15:0]                 instr_data,
  output logic [15:0]                 instr_pc_plus2,
  input  logic                        instr_ready,
  output logic [3:0]                  occupancy
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0]  MAX_O   = 2'(MAX_OUTSTANDING);
  localparam logic [3:0]  DEPTH_W = 4'(DEPTH);
  localparam logic [15:0] RST_PC  = {RESET_PC[15:1], 1'b0};

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   resp_pc_q, resp_pc_d;
  logic [1:0]    out_q, out_d;
  logic [1:0]    drop_q, drop_d;
  logic [3:0]    occ_q, occ_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]   data_q [DEPTH];
  logic [15:0]   data_d [DEPTH];
  logic [15:0]   pcp2_q [DEPTH];
  logic [15:0]   pcp2_d [DEPTH];

  logic [3:0] reserved;
  logic       req_ok;
  logic       accept;
  logic       resp;
  logic       push;
  logic       pop;

  // Reserve FIFO space for every request in flight so a
  // response can never find the queue full.
  always_comb begin
    reserved = occ_q + {2'b00, out_q};
    req_ok   = reset && !halt && !redirect_valid &&
               (out_q < MAX_O) && (reserved < DEPTH_W);
    accept   = req_ok && imem.imem_req_ready;
    resp     = imem.imem_resp_valid && (out_q != 2'd0);
    push     = resp && (drop_q == 2'd0) && !redirect_valid;
    pop      = (occ_q != 4'd0) && instr_ready && !redirect_valid;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    data_d     = data_q;
    pcp2_d     = pcp2_q;

    unique case ({accept, resp})
      2'b10:   out_d = out_q + 2'd1;
      2'b01:   out_d = out_q - 2'd1;
      default: out_d = out_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[15:1], 1'b0};
      resp_pc_d  = {redirect_pc[15:1], 1'b0};
      occ_d      = 4'd0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // everything still in flight belongs to the old path
      drop_d     = resp ? out_q - 2'd1 : out_q;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 16'd2;
      if (resp && drop_q != 2'd0) drop_d = drop_q - 2'd1;
      if (push) begin
        data_d[wr_ptr_q] = imem.imem_resp_data;
        pcp2_d[wr_ptr_q] = resp_pc_q + 16'd2;
        wr_ptr_d         = wr_ptr_q + AW'(1);
        resp_pc_d        = resp_pc_q + 16'd2;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      occ_d = occ_q + {3'b000, push} - {3'b000, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RST_PC;
      resp_pc_q  <= RST_PC;
      out_q      <= 2'd0;
      drop_q     <= 2'd0;
      occ_q      <= 4'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= 16'h0000;
        pcp2_q[i] <= 16'h0000;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      data_q     <= data_d;
      pcp2_q     <= pcp2_d;
    end
  end

  assign imem.imem_req_valid = req_ok;
  assign imem.imem_req_addr  = fetch_pc_q;
  assign instr_valid         = (occ_q != 4'd0);
  assign instr_data          = data_q[rd_ptr_q];
  assign instr_pc_plus2      = pcp2_q[rd_ptr_q];
  assign occupancy           = occ_q;

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of prefetch FIFO entries (power of two, 2..8).
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of accepted but not yet answered imem requests (1..3).
REQ-003 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous active-low reset (0 = reset).
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: a taken branch, jump or jr from the pipeline.
REQ-008 The block SHALL have port redirect_pc, input, 16 bits: the redirect target.
REQ-009 The block SHALL have port halt, input, 1 bit: stop issuing new fetches.
REQ-010 The block SHALL have port imem_req_valid, output, 1 bit: fetch request.
REQ-011 The block SHALL have port imem_req_addr, output, 16 bits: fetch byte address.
REQ-012 The block SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-013 The block SHALL have port imem_resp_valid, input, 1 bit: response strobe; responses return in request order.
REQ-014 The block SHALL have port imem_resp_data, input, 16 bits: the fetched instruction.
REQ-015 The block SHALL have port instr_valid, output, 1 bit: the FIFO head is valid.
REQ-016 The block SHALL have port instr_data, output, 16 bits: the head instruction, which feeds the pipeline instruction input.
REQ-017 The block SHALL have port instr_pc_plus2, output, 16 bits: the head instruction address + 2.
REQ-018 The block SHALL have port instr_ready, input, 1 bit: the pipeline consumes the head (low on load stall or halt).
REQ-019 The block SHALL have port occupancy, output, 4 bits: the number of valid FIFO entries.

Function
REQ-020 The block SHALL hold fetch_pc (next request address) and resp_pc (address of the next expected response), both 16 bits, with bit0 always 0.
REQ-021 The block SHALL drive imem_req_valid = !halt && !redirect_valid && outstanding < MAX_OUTSTANDING && (occupancy + outstanding) < DEPTH, with imem_req_addr = fetch_pc.
REQ-022 On request accept (imem_req_valid && imem_req_ready), the block SHALL set fetch_pc <= fetch_pc + 2 (wraps 16'hFFFE -> 16'h0000) and increment outstanding.
REQ-023 On imem_resp_valid, the block SHALL decrement outstanding; accept and response in the same cycle SHALL leave it unchanged; imem_resp_valid with outstanding == 0 SHALL be ignored.
REQ-024 When drop_count == 0, a response SHALL push {imem_resp_data, resp_pc + 2} into the FIFO and set resp_pc <= resp_pc + 2.
REQ-025 When drop_count != 0, a response SHALL be discarded and drop_count decremented.
REQ-026 The space reservation in REQ-021 SHALL guarantee no overflow; push on a full FIFO SHALL not occur.
REQ-027 Push latency SHALL be 1 cycle: a response in cycle N makes instr_valid high in cycle N+1; there is no bypass.
REQ-028 The block SHALL drive instr_valid = (occupancy != 0), with instr_data and instr_pc_plus2 taken from the head entry, registered and stable while not popped.
REQ-029 The block SHALL pop when instr_valid && instr_ready && !redirect_valid; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 On redirect_valid, the block SHALL clear the FIFO (occupancy <= 0), set fetch_pc and resp_pc <= {redirect_pc[15:1], 1'b0}, and set drop_count <= outstanding minus 1 if a response arrives the same cycle, else outstanding; that same-cycle response SHALL be discarded.
REQ-032 A redirect SHALL take priority over pop, push and request in the same cycle.
REQ-033 While halt is high, the block SHALL issue no requests, while outstanding responses are still absorbed and the FIFO still drains.
REQ-034 outstanding and drop_count SHALL be 2-bit saturating-safe counters that never underflow.

Reset
REQ-035 While reset == 0 at a clock edge, the block SHALL set fetch_pc and resp_pc = RESET_PC, occupancy, outstanding and drop_count = 0, instr_valid = 0, instr_data = 16'h0000, instr_pc_plus2 = 16'h0000, imem_req_valid = 0.
REQ-036 Reset asserted mid-operation SHALL abandon in-flight requests; responses arriving while reset == 0 SHALL be ignored; the first request SHALL issue in the cycle after release.

Verification
REQ-037 The bench SHALL cover: zero-wait memory (ready=1, response 1 cycle later), instr_ready=1 -> addresses 0,2,4,... in order, instr_pc_plus2 = addr+2, one instruction per cycle sustained.
REQ-038 The bench SHALL cover: instr_ready=0 for 10 cycles -> occupancy saturates at 4, imem_req_valid low, no entry lost; on release, instructions 0..6 are delivered in order.
REQ-039 The bench SHALL cover: redirect to 16'h0041 with 2 outstanding -> both stale responses dropped, next request addr 16'h0040, first delivered instr_pc_plus2 = 16'h0042.
REQ-040 The bench SHALL cover: redirect in the same cycle as a response and a pop -> FIFO empty next cycle, drop_count = outstanding-1, no stale instruction is delivered.
REQ-041 The bench SHALL cover: halt raised with 2 outstanding -> no new requests, 2 responses queued, occupancy = 2.
REQ-042 The bench SHALL cover: reset pulsed with 1 outstanding -> all outputs at reset values, a late response is ignored, and the next request addr = RESET_PC.
